// File: rtl/alarm_clock_core.sv
// 24h time-of-day counter with a seconds prescaler, button setting of time and alarm,
// a 12h display decode and an alarm ring/snooze/stop state machine.
module alarm_clock_core #(
   parameter int TICK_DIV   = 1000,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_MIN = 5,
   parameter int AL_RST_HR  = 7,
   parameter int AL_RST_MIN = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hr_inc,
   input  logic       min_inc,
   input  logic       set_sel,
   input  logic       alarm_en,
   input  logic       snooze,
   input  logic       stop,
   output logic [4:0] hr,
   output logic [5:0] min,
   output logic [5:0] sec,
   output logic [4:0] al_hr,
   output logic [5:0] al_min,
   output logic [3:0] hr12,
   output logic       pm,
   output logic       sec_tick,
   output logic       ring,
   output logic       snoozing
);

   localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SN_SEC = SNOOZE_MIN * 60;
   localparam int RW     = $clog2(RING_SEC + 1);
   localparam int SW     = $clog2(SN_SEC + 1);
   localparam logic [PW-1:0] CNT_LAST  = PW'(TICK_DIV - 1);
   localparam logic [RW-1:0] RING_LOAD = RW'(RING_SEC);
   localparam logic [SW-1:0] SN_LOAD   = SW'(SN_SEC);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RING = 2'd1, ST_SNOOZE = 2'd2} state_t;

   function automatic logic [5:0] inc60(input logic [5:0] v);
      return (v == 6'd59) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [4:0] inc24(input logic [4:0] v);
      return (v == 5'd23) ? 5'd0 : v + 5'd1;
   endfunction

   logic [PW-1:0] cnt_r, cnt_nx_s;
   logic          sec_tick_r, trig_r, tick_upd_s;
   logic          hr_prev_r, min_prev_r, sn_prev_r, stop_prev_r;
   logic          hr_pe_s, min_pe_s, sn_pe_s, stop_pe_s;
   logic [4:0]    hr_r, hr_nx_s, al_hr_r, al_hr_nx_s;
   logic [5:0]    min_r, min_nx_s, sec_r, sec_nx_s, al_min_r, al_min_nx_s;
   state_t        state_r, state_nx_s;
   logic [RW-1:0] ring_cnt_r, ring_cnt_nx_s;
   logic [SW-1:0] sn_cnt_r, sn_cnt_nx_s;
   logic          ring_r, ring_nx_s, snoozing_r, snoozing_nx_s;

   assign cnt_nx_s  = (cnt_r == CNT_LAST) ? {PW{1'b0}} : cnt_r + PW'(1);
   assign hr_pe_s   = hr_inc & ~hr_prev_r;
   assign min_pe_s  = min_inc & ~min_prev_r;
   assign sn_pe_s   = snooze & ~sn_prev_r;
   assign stop_pe_s = stop & ~stop_prev_r;

   // Prescaler, tick pulse and button history; history resets high so held buttons stay quiet.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_r       <= {PW{1'b0}};
         sec_tick_r  <= 1'b0;
         hr_prev_r   <= 1'b1;
         min_prev_r  <= 1'b1;
         sn_prev_r   <= 1'b1;
         stop_prev_r <= 1'b1;
      end else begin
         cnt_r       <= cnt_nx_s;
         sec_tick_r  <= (cnt_nx_s == CNT_LAST);
         hr_prev_r   <= hr_inc;
         min_prev_r  <= min_inc;
         sn_prev_r   <= snooze;
         stop_prev_r <= stop;
      end
   end

   // Time/alarm next values: a set pulse pre-empts the tick, so that second is lost.
   always_comb begin
      hr_nx_s     = hr_r;
      min_nx_s    = min_r;
      sec_nx_s    = sec_r;
      al_hr_nx_s  = al_hr_r;
      al_min_nx_s = al_min_r;
      tick_upd_s  = 1'b0;
      if (!set_sel && min_pe_s) begin
         min_nx_s = inc60(min_r);
         hr_nx_s  = (min_r == 6'd59) ? inc24(hr_r) : hr_r;
      end else if (!set_sel && hr_pe_s) begin
         hr_nx_s = inc24(hr_r);
      end else if (sec_tick_r) begin
         tick_upd_s = 1'b1;
         sec_nx_s   = inc60(sec_r);
         if (sec_r == 6'd59) begin
            min_nx_s = inc60(min_r);
            hr_nx_s  = (min_r == 6'd59) ? inc24(hr_r) : hr_r;
         end else begin
            min_nx_s = min_r;
         end
      end else begin
         tick_upd_s = 1'b0;
      end
      if (set_sel) begin
         al_min_nx_s = min_pe_s ? inc60(al_min_r) : al_min_r;
         al_hr_nx_s  = hr_pe_s ? inc24(al_hr_r) : al_hr_r;
      end else begin
         al_min_nx_s = al_min_r;
         al_hr_nx_s  = al_hr_r;
      end
   end

   // Time and alarm registers plus the alarm-match flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hr_r     <= 5'd0;
         min_r    <= 6'd0;
         sec_r    <= 6'd0;
         al_hr_r  <= 5'(AL_RST_HR);
         al_min_r <= 6'(AL_RST_MIN);
         trig_r   <= 1'b0;
      end else begin
         hr_r     <= hr_nx_s;
         min_r    <= min_nx_s;
         sec_r    <= sec_nx_s;
         al_hr_r  <= al_hr_nx_s;
         al_min_r <= al_min_nx_s;
         trig_r   <= tick_upd_s && (hr_nx_s == al_hr_r) && (min_nx_s == al_min_r)
                     && (sec_nx_s == 6'd0);
      end
   end

   // Alarm state register, countdowns and registered FSM outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         ring_cnt_r <= {RW{1'b0}};
         sn_cnt_r   <= {SW{1'b0}};
         ring_r     <= 1'b0;
         snoozing_r <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         ring_cnt_r <= ring_cnt_nx_s;
         sn_cnt_r   <= sn_cnt_nx_s;
         ring_r     <= ring_nx_s;
         snoozing_r <= snoozing_nx_s;
      end
   end

   // Alarm next-state: stop beats snooze, countdowns expire on the tick that reaches zero.
   always_comb begin
      state_nx_s    = state_r;
      ring_cnt_nx_s = ring_cnt_r;
      sn_cnt_nx_s   = sn_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (trig_r && alarm_en) begin
               state_nx_s    = ST_RING;
               ring_cnt_nx_s = RING_LOAD;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RING: begin
            if (stop_pe_s || !alarm_en) begin
               state_nx_s    = ST_IDLE;
               ring_cnt_nx_s = {RW{1'b0}};
            end else if (sn_pe_s) begin
               state_nx_s    = ST_SNOOZE;
               ring_cnt_nx_s = {RW{1'b0}};
               sn_cnt_nx_s   = SN_LOAD;
            end else if (sec_tick_r) begin
               if (ring_cnt_r <= RW'(1)) begin
                  state_nx_s    = ST_IDLE;
                  ring_cnt_nx_s = {RW{1'b0}};
               end else begin
                  ring_cnt_nx_s = ring_cnt_r - RW'(1);
               end
            end else begin
               state_nx_s = ST_RING;
            end
         end
         ST_SNOOZE: begin
            if (stop_pe_s || !alarm_en) begin
               state_nx_s  = ST_IDLE;
               sn_cnt_nx_s = {SW{1'b0}};
            end else if (sec_tick_r) begin
               if (sn_cnt_r <= SW'(1)) begin
                  state_nx_s    = ST_RING;
                  sn_cnt_nx_s   = {SW{1'b0}};
                  ring_cnt_nx_s = RING_LOAD;
               end else begin
                  sn_cnt_nx_s = sn_cnt_r - SW'(1);
               end
            end else begin
               state_nx_s = ST_SNOOZE;
            end
         end
         default: begin
            state_nx_s    = ST_IDLE;
            ring_cnt_nx_s = {RW{1'b0}};
            sn_cnt_nx_s   = {SW{1'b0}};
         end
      endcase
   end

   // FSM output decode, taken from the next state so the outputs come straight from flops.
   always_comb begin
      ring_nx_s     = (state_nx_s == ST_RING);
      snoozing_nx_s = (state_nx_s == ST_SNOOZE);
   end

   // 12h display decode: midnight shows 12, afternoon folds down by 12.
   always_comb begin
      if (hr_r == 5'd0) begin
         hr12 = 4'd12;
      end else if (hr_r > 5'd12) begin
         hr12 = 4'(hr_r - 5'd12);
      end else begin
         hr12 = hr_r[3:0];
      end
      pm = (hr_r >= 5'd12);
   end

   assign hr       = hr_r;
   assign min      = min_r;
   assign sec      = sec_r;
   assign al_hr    = al_hr_r;
   assign al_min   = al_min_r;
   assign sec_tick = sec_tick_r;
   assign ring     = ring_r;
   assign snoozing = snoozing_r;

endmodule

// File: tb/tb_alarm_clock_core.sv
// Bench for alarm_clock_core: directed stimulus queues expectations, a negedge monitor checks them.
module tb_alarm_clock_core;

   localparam int S_HR = 0, S_MIN = 1, S_SEC = 2, S_ALHR = 3, S_ALMIN = 4,
                  S_HR12 = 5, S_PM = 6, S_RING = 7, S_SNZ = 8, S_TICK = 9;

   typedef struct {
      string name;
      int    sel;
      int    val;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, hr_inc, min_inc, set_sel, alarm_en, snooze, stop;
   logic [4:0] hr, al_hr;
   logic [5:0] min, sec, al_min;
   logic [3:0] hr12;
   logic       pm, sec_tick, ring, snoozing;

   exp_t exp_q[$];
   exp_t cur;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   ph      = 0;

   alarm_clock_core #(
      .TICK_DIV(4), .RING_SEC(3), .SNOOZE_MIN(1), .AL_RST_HR(7), .AL_RST_MIN(0)
   ) dut (
      .clk(clk), .rst(rst), .hr_inc(hr_inc), .min_inc(min_inc), .set_sel(set_sel),
      .alarm_en(alarm_en), .snooze(snooze), .stop(stop), .hr(hr), .min(min), .sec(sec),
      .al_hr(al_hr), .al_min(al_min), .hr12(hr12), .pm(pm), .sec_tick(sec_tick),
      .ring(ring), .snoozing(snoozing)
   );

   always #5 clk = ~clk;

   // Bench copy of the prescaler phase: ph==3 marks a cycle whose closing edge is a tick.
   always @(posedge clk) begin
      if (!rst) ph <= 0;
      else      ph <= (ph == 3) ? 0 : ph + 1;
   end

   function automatic logic [31:0] getv(input int sel);
      case (sel)
         S_HR:    return {27'd0, hr};
         S_MIN:   return {26'd0, min};
         S_SEC:   return {26'd0, sec};
         S_ALHR:  return {27'd0, al_hr};
         S_ALMIN: return {26'd0, al_min};
         S_HR12:  return {28'd0, hr12};
         S_PM:    return {31'd0, pm};
         S_RING:  return {31'd0, ring};
         S_SNZ:   return {31'd0, snoozing};
         S_TICK:  return {31'd0, sec_tick};
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   // Monitor: drain every pending expectation against the settled outputs.
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         n_tests++;
         if (getv(cur.sel) !== cur.val) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", cur.name, getv(cur.sel), cur.val);
         end
      end
   end

   task automatic expect_val(input string name, input int sel, input int val);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic check_now(input string name, input int sel, input int val);
      n_tests++;
      if (getv(sel) !== val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (immediate)", name, getv(sel), val);
      end
   endtask

   task automatic expect_time(input string name, input int h, input int m, input int s);
      expect_val({name, " hr"}, S_HR, h);
      expect_val({name, " min"}, S_MIN, m);
      expect_val({name, " sec"}, S_SEC, s);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic to_tick_cycle();
      while (ph != 3) step();
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         to_tick_cycle();
         step();
      end
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: hr_inc  = v;
         1: min_inc = v;
         2: snooze  = v;
         default: stop = v;
      endcase
   endtask

   // One press: high for one sampled edge, low for the next; optionally aligned to a tick edge.
   task automatic press(input int b, input int n, input bit on_tick);
      for (int i = 0; i < n; i++) begin
         if (on_tick) to_tick_cycle();
         set_btn(b, 1'b1);
         step();
         set_btn(b, 1'b0);
         step();
      end
   endtask

   task automatic wait_ring(input string name);
      for (int i = 0; i < 400 && ring !== 1'b1; i++) step();
      if (ring !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: ring wait expired", name);
      end
      expect_val({name, " ring up"}, S_RING, 1);
   endtask

   initial begin
      rst = 1'b0; hr_inc = 1'b1; min_inc = 1'b1; snooze = 1'b1; stop = 1'b1;
      set_sel = 1'b0; alarm_en = 1'b0;

      // 1: reset with buttons held, no pulse on release
      step();
      check_now("t1 reset hr now", S_HR, 0);
      check_now("t1 reset ring now", S_RING, 0);
      check_now("t1 reset al_hr now", S_ALHR, 7);
      expect_time("t1 reset", 0, 0, 0);
      expect_val("t1 al_hr", S_ALHR, 7);
      expect_val("t1 al_min", S_ALMIN, 0);
      expect_val("t1 hr12", S_HR12, 12);
      expect_val("t1 pm", S_PM, 0);
      expect_val("t1 ring", S_RING, 0);
      expect_val("t1 snoozing", S_SNZ, 0);
      expect_val("t1 tick", S_TICK, 0);
      rst = 1'b1;
      step(); step();
      expect_val("t1 held hr", S_HR, 0);
      expect_val("t1 held min", S_MIN, 0);
      expect_val("t1 tick low", S_TICK, 0);
      step();
      expect_val("t1 tick high", S_TICK, 1);
      hr_inc = 1'b0; min_inc = 1'b0; snooze = 1'b0; stop = 1'b0;
      step();
      expect_time("t1 first sec", 0, 0, 1);
      expect_val("t1 tick done", S_TICK, 0);

      // 2: 23:59:58 -> midnight, then 12 and 13 o'clock display
      wait_ticks(57);
      expect_val("t2 sec58", S_SEC, 58);
      press(0, 23, 1'b1);
      press(1, 59, 1'b1);
      expect_time("t2 set", 23, 59, 58);
      expect_val("t2 hr12 23", S_HR12, 11);
      expect_val("t2 pm 23", S_PM, 1);
      wait_ticks(1);
      expect_time("t2 tick1", 23, 59, 59);
      wait_ticks(1);
      expect_time("t2 midnight", 0, 0, 0);
      expect_val("t2 hr12 0", S_HR12, 12);
      expect_val("t2 pm 0", S_PM, 0);
      press(0, 12, 1'b1);
      expect_val("t2 hr12 12", S_HR12, 12);
      expect_val("t2 pm 12", S_PM, 1);
      press(0, 1, 1'b1);
      expect_time("t2 13h", 13, 0, 0);
      expect_val("t2 hr12 13", S_HR12, 1);
      expect_val("t2 pm 13", S_PM, 1);

      // 3: alarm at 07:00 rings one cycle after the match, stops after 3 ticks
      wait_ticks(59);
      press(0, 17, 1'b1);
      press(1, 59, 1'b1);
      expect_time("t3 set", 6, 59, 59);
      alarm_en = 1'b1;
      to_tick_cycle();
      step();
      expect_time("t3 match", 7, 0, 0);
      expect_val("t3 ring not yet", S_RING, 0);
      step();
      expect_val("t3 ring rise", S_RING, 1);
      wait_ticks(2);
      expect_val("t3 ring 2 ticks", S_RING, 1);
      wait_ticks(1);
      expect_val("t3 ring auto off", S_RING, 0);
      expect_val("t3 snoozing", S_SNZ, 0);
      expect_val("t3 sec", S_SEC, 3);

      // 4: alarm 07:01, snooze 60 ticks, ring again, stop
      set_sel = 1'b1;
      press(1, 1, 1'b0);
      set_sel = 1'b0;
      expect_val("t4 al_min", S_ALMIN, 1);
      expect_val("t4 al_hr", S_ALHR, 7);
      wait_ring("t4");
      expect_time("t4 at ring", 7, 1, 0);
      snooze = 1'b1;
      step();
      expect_val("t4 snooze ring", S_RING, 0);
      expect_val("t4 snooze state", S_SNZ, 1);
      snooze = 1'b0;
      step();
      wait_ticks(59);
      expect_val("t4 snooze 59", S_SNZ, 1);
      expect_val("t4 ring 59", S_RING, 0);
      wait_ticks(1);
      expect_val("t4 re-ring", S_RING, 1);
      expect_val("t4 snz off", S_SNZ, 0);
      stop = 1'b1;
      step();
      expect_val("t4 stop ring", S_RING, 0);
      expect_val("t4 stop snz", S_SNZ, 0);
      stop = 1'b0;
      step();
      press(2, 1, 1'b0);
      expect_val("t4 idle snooze", S_SNZ, 0);

      // 5: min_inc on a tick edge drops the tick; alarm minute wraps without carry
      alarm_en = 1'b0;
      rst = 1'b0;
      step();
      rst = 1'b1;
      expect_time("t5 reset", 0, 0, 0);
      wait_ticks(59);
      press(0, 10, 1'b1);
      press(1, 59, 1'b1);
      expect_time("t5 set", 10, 59, 59);
      press(1, 1, 1'b1);
      expect_time("t5 carry", 11, 0, 59);
      set_sel = 1'b1;
      press(1, 59, 1'b0);
      expect_val("t5 al_min 59", S_ALMIN, 59);
      press(1, 1, 1'b0);
      expect_val("t5 al_min wrap", S_ALMIN, 0);
      expect_val("t5 al_hr no carry", S_ALHR, 7);
      expect_time("t5 still ticking", 11, 1, 29);

      // 6: reset while ringing
      press(0, 4, 1'b0);
      press(1, 2, 1'b0);
      expect_val("t6 al_hr", S_ALHR, 11);
      expect_val("t6 al_min", S_ALMIN, 2);
      set_sel = 1'b0;
      alarm_en = 1'b1;
      wait_ring("t6");
      expect_time("t6 at ring", 11, 2, 0);
      rst = 1'b0;
      step();
      rst = 1'b1;
      check_now("t6 ring now", S_RING, 0);
      expect_val("t6 ring", S_RING, 0);
      expect_val("t6 snoozing", S_SNZ, 0);
      expect_time("t6 time", 0, 0, 0);
      expect_val("t6 al_hr rst", S_ALHR, 7);
      step();
      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
